hazard_unit_param: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage MIPS core, the successor to the fixed one-cycle hazard FSM. It sits in decode and drives PC/IF-ID write enables, the ID/EX bubble and the next-PC select. It detects load-use RAW hazards, sequences jump and branch flushes, and supports configurable load-use and branch-resolution latencies. It also honours an external pipeline hold and keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_if.sv | 41 ++++
 rtl/hazard_unit_param.sv | 185 ++++++++++++++++++
 tb/tb_hazard_unit_param.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Decode-stage control bus between the pipeline (master) and the hazard unit (slave).
// Signalling: there is no valid/ready handshake on this bus. Every signal is a
// level sampled on each rising clock edge; requests (Jump, Branch, load info) are
// presented for the cycle in which the instruction sits in ID, and the unit's
// enables/selects are combinational responses in that same cycle.
interface hazard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  // Requests and operand information from ID/EX
  logic              Jump;
  logic              Branch;
  logic              ALUZero;
  logic              memReadEX;
  logic              UseImmed;
  logic              UseShmt;
  logic [REG_AW-1:0] CurrRs;
  logic [REG_AW-1:0] CurrRt;
  logic [REG_AW-1:0] PrevRw;
  logic              Hold;
  logic              CntClr;

  // Pipeline controls and performance counter back to the datapath
  logic              PC_Write;
  logic              IF_Write;
  logic              bubble;
  logic [1:0]        addrSel;
  logic [CNT_W-1:0]  StallCount;

  modport master (
    output Jump, Branch, ALUZero, memReadEX, UseImmed, UseShmt,
           CurrRs, CurrRt, PrevRw, Hold, CntClr,
    input  PC_Write, IF_Write, bubble, addrSel, StallCount
  );

  modport slave (
    input  Jump, Branch, ALUZero, memReadEX, UseImmed, UseShmt,
           CurrRs, CurrRt, PrevRw, Hold, CntClr,
    output PC_Write, IF_Write, bubble, addrSel, StallCount
  );
endinterface

// File: rtl/hazard_unit_param.sv
// Parametrised decode-stage hazard controller: load-use stalls, jump flush,
// branch wait/redirect with configurable latencies, external hold, and a
// saturating stall-cycle counter. State and the latency down-counter are
// exposed on debug outputs.
module hazard_unit_param #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_LAT   = 1,
  parameter int CNT_W    = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  hazard_if.slave    hz,
  output logic [2:0] dbg_state_o,
  output logic [2:0] dbg_cnt_o
);

  // Latencies are at most 8, so the remaining-cycle counter never exceeds 7.
  localparam int CW = 3;
  localparam logic [CW-1:0] LD_INIT = (LOAD_LAT > 1) ? CW'(LOAD_LAT - 2) : '0;
  localparam logic [CW-1:0] BR_INIT = CW'(BR_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_JUMP     = 3'd1,
    S_BR_WAIT  = 3'd2,
    S_BR_TAKEN = 3'd3,
    S_LD_STALL = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [REG_AW-1:0] rs, rt, rw;
  logic rs_hit, rt_hit, load_haz;

  logic       pc_write, if_write, bubble;
  logic [1:0] addr_sel;

  assign rs = hz.CurrRs;
  assign rt = hz.CurrRt;
  assign rw = hz.PrevRw;

  // Rs is read by everything except shift-by-immediate forms; Rt only by
  // pure register-register forms. Register 0 is never a real dependency.
  assign rs_hit   = (rs == rw) && !(hz.UseImmed && hz.UseShmt);
  assign rt_hit   = (rt == rw) && !hz.UseImmed && !hz.UseShmt;
  assign load_haz = hz.memReadEX && (rw != '0) && (rs_hit || rt_hit);

  // State register: FSM state and latency counter
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; Hold freezes everything so the sequence resumes intact
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!hz.Hold) begin
      case (state_q)
        S_IDLE: begin
          if (hz.Jump) begin
            state_d = S_JUMP;
          end else if (load_haz) begin
            // The detect cycle is already the first bubble.
            if (LOAD_LAT > 1) begin
              state_d = S_LD_STALL;
              cnt_d   = LD_INIT;
            end
          end else if (hz.Branch) begin
            state_d = S_BR_WAIT;
            cnt_d   = BR_INIT;
          end
        end
        S_JUMP: begin
          state_d = S_IDLE;
        end
        S_LD_STALL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 3'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BR_WAIT: begin
          // ALUZero is only trustworthy in the final wait cycle.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 3'd1;
          end else if (hz.ALUZero) begin
            state_d = S_BR_TAKEN;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BR_TAKEN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic: combinational from state, counter and current inputs
  always_comb begin
    pc_write = 1'b1;
    if_write = 1'b1;
    bubble   = 1'b0;
    addr_sel = 2'b00;
    if (Rst) begin
      // Defaults while in reset, whatever the other inputs say.
      pc_write = 1'b1;
    end else if (hz.Hold) begin
      pc_write = 1'b0;
      if_write = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A jump wins and issues normally; a load hazard stalls in place.
          if (!hz.Jump && load_haz) begin
            pc_write = 1'b0;
            if_write = 1'b0;
            bubble   = 1'b1;
          end
        end
        S_JUMP: begin
          if_write = 1'b0;
          bubble   = 1'b1;
          addr_sel = 2'b01;
        end
        S_LD_STALL, S_BR_WAIT: begin
          pc_write = 1'b0;
          if_write = 1'b0;
          bubble   = 1'b1;
        end
        S_BR_TAKEN: begin
          if_write = 1'b0;
          bubble   = 1'b1;
          addr_sel = 2'b10;
        end
        default: begin
          pc_write = 1'b1;
        end
      endcase
    end
  end

  // Stall counter next value: clear beats increment, saturates at all-ones
  always_comb begin
    stall_d = stall_q;
    if (hz.CntClr) begin
      stall_d = '0;
    end else if (bubble && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Stall counter register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign hz.PC_Write   = pc_write;
  assign hz.IF_Write   = if_write;
  assign hz.bubble     = bubble;
  assign hz.addrSel    = addr_sel;
  assign hz.StallCount = stall_q;

  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_hazard_unit_param.sv
// Bench for hazard_unit_param with LOAD_LAT=3, BR_LAT=2, CNT_W=4.
module tb_hazard_unit_param;

  localparam int RAW  = 5;
  localparam int LL   = 3;
  localparam int BL   = 2;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic [2:0] dbg_state;
  logic [2:0] dbg_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_if #(.REG_AW(RAW), .CNT_W(CW)) bus ();

  hazard_unit_param #(
    .REG_AW(RAW), .LOAD_LAT(LL), .BR_LAT(BL), .CNT_W(CW)
  ) dut (
    .Clk(clk),
    .Rst(rst),
    .hz(bus.slave),
    .dbg_state_o(dbg_state),
    .dbg_cnt_o(dbg_cnt)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic clear_in();
    bus.Jump = 0; bus.Branch = 0; bus.ALUZero = 0; bus.memReadEX = 0;
    bus.UseImmed = 0; bus.UseShmt = 0; bus.CurrRs = '0; bus.CurrRt = '0;
    bus.PrevRw = '0; bus.Hold = 0; bus.CntClr = 0;
  endtask

  task automatic set_load(input int rs, input int rt, input int rw,
                          input bit imm, input bit shm);
    bus.memReadEX = 1;
    bus.CurrRs = RAW'(rs); bus.CurrRt = RAW'(rt); bus.PrevRw = RAW'(rw);
    bus.UseImmed = imm; bus.UseShmt = shm;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / behavioural model ----------------
  // The model keeps a queue of scheduled response cycles created when a
  // request is accepted while idle: 1 load stall, 2 jump flush,
  // 3 branch wait, 4 branch resolve, 5 branch redirect.
  logic [7:0] exp_q[$];
  int m_cnt = 0;

  function automatic bit model_haz();
    if (!bus.memReadEX || bus.PrevRw == '0) return 1'b0;
    if (bus.CurrRs == bus.PrevRw && !(bus.UseImmed && bus.UseShmt)) return 1'b1;
    if (bus.CurrRt == bus.PrevRw && !bus.UseImmed && !bus.UseShmt) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    logic e_pc, e_if, e_bub;
    logic [1:0] e_sel;
    logic [7:0] nxt;
    e_pc = 1; e_if = 1; e_bub = 0; e_sel = 2'b00;
    if (rst) begin
      e_pc = 1;
    end else if (bus.Hold) begin
      e_pc = 0; e_if = 0;
    end else if (exp_q.size() > 0) begin
      case (exp_q[0])
        8'd2:    begin e_if = 0; e_bub = 1; e_sel = 2'b01; end
        8'd5:    begin e_if = 0; e_bub = 1; e_sel = 2'b10; end
        default: begin e_pc = 0; e_if = 0; e_bub = 1; end
      endcase
    end else if (!bus.Jump && model_haz()) begin
      e_pc = 0; e_if = 0; e_bub = 1;
    end

    chk("m_pc_write", int'(bus.PC_Write), int'(e_pc));
    chk("m_if_write", int'(bus.IF_Write), int'(e_if));
    chk("m_bubble",   int'(bus.bubble),   int'(e_bub));
    chk("m_addrsel",  int'(bus.addrSel),  int'(e_sel));
    chk("m_stallcnt", int'(bus.StallCount), m_cnt);

    // Advance the model to the state after the coming rising edge.
    if (rst) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (bus.CntClr) m_cnt = 0;
      else if (e_bub && m_cnt < MAXC) m_cnt++;
      if (!bus.Hold) begin
        if (exp_q.size() > 0) begin
          nxt = exp_q.pop_front();
          if (nxt == 8'd4 && bus.ALUZero) exp_q.push_back(8'd5);
        end else if (bus.Jump) begin
          exp_q.push_back(8'd2);
        end else if (model_haz()) begin
          repeat (LL - 1) exp_q.push_back(8'd1);
        end else if (bus.Branch) begin
          repeat (BL - 1) exp_q.push_back(8'd3);
          exp_q.push_back(8'd4);
        end
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    rst = 1;
    clear_in();
    tick();
    tick();
    rst = 0;

    // Idle after reset
    neg();
    chk("rst_pc", int'(bus.PC_Write), 1);
    chk("rst_if", int'(bus.IF_Write), 1);
    chk("rst_bub", int'(bus.bubble), 0);
    chk("rst_sel", int'(bus.addrSel), 0);
    chk("rst_cnt", int'(bus.StallCount), 0);
    tick();

    // Load-use on Rs: three bubble cycles
    set_load(5, 0, 5, 0, 0);
    neg(); chk("ld_c0_bub", int'(bus.bubble), 1); chk("ld_c0_pc", int'(bus.PC_Write), 0);
    tick(); clear_in();
    neg(); chk("ld_c1_bub", int'(bus.bubble), 1); chk("ld_c1_if", int'(bus.IF_Write), 0);
    tick();
    neg(); chk("ld_c2_bub", int'(bus.bubble), 1);
    tick();
    neg(); chk("ld_done_bub", int'(bus.bubble), 0); chk("ld_done_pc", int'(bus.PC_Write), 1);
    chk("ld_cnt3", int'(bus.StallCount), 3);
    tick();

    // PrevRw = 0 never stalls
    set_load(0, 0, 0, 0, 0);
    neg(); chk("rw0_bub", int'(bus.bubble), 0);
    tick();
    // Immediate form, match only on Rt
    set_load(3, 7, 7, 1, 0);
    neg(); chk("imm_rt_bub", int'(bus.bubble), 0);
    tick();
    // Shift-immediate form ignores Rs
    set_load(7, 2, 7, 1, 1);
    neg(); chk("shimm_rs_bub", int'(bus.bubble), 0);
    tick();
    // Register form, match on Rt
    set_load(2, 7, 7, 0, 0);
    neg(); chk("rr_rt_bub", int'(bus.bubble), 1);
    tick(); clear_in();
    tick();
    tick();
    neg(); chk("rr_rt_done", int'(bus.bubble), 0); chk("rr_rt_cnt6", int'(bus.StallCount), 6);
    tick();

    // Branch taken: issue, two waits, redirect
    bus.Branch = 1;
    neg(); chk("bt_issue_pc", int'(bus.PC_Write), 1); chk("bt_issue_bub", int'(bus.bubble), 0);
    tick(); clear_in();
    neg(); chk("bt_w1_bub", int'(bus.bubble), 1); chk("bt_w1_pc", int'(bus.PC_Write), 0);
    tick(); bus.ALUZero = 1;
    neg(); chk("bt_w2_bub", int'(bus.bubble), 1);
    tick(); bus.ALUZero = 0;
    neg(); chk("bt_redir_sel", int'(bus.addrSel), 2); chk("bt_redir_pc", int'(bus.PC_Write), 1);
    chk("bt_redir_if", int'(bus.IF_Write), 0);
    tick();
    neg(); chk("bt_after_sel", int'(bus.addrSel), 0); chk("bt_cnt9", int'(bus.StallCount), 9);
    tick();

    // ALUZero high only in first wait: not taken
    bus.Branch = 1;
    tick(); clear_in(); bus.ALUZero = 1;
    tick(); bus.ALUZero = 0;
    neg(); chk("bn_w2_bub", int'(bus.bubble), 1);
    tick();
    neg(); chk("bn_after_sel", int'(bus.addrSel), 0); chk("bn_after_bub", int'(bus.bubble), 0);
    chk("bn_cnt11", int'(bus.StallCount), 11);
    tick();

    // Jump, load hazard and branch together: jump wins
    set_load(5, 0, 5, 0, 0); bus.Jump = 1; bus.Branch = 1;
    neg(); chk("jp_issue_bub", int'(bus.bubble), 0); chk("jp_issue_pc", int'(bus.PC_Write), 1);
    tick(); clear_in();
    neg(); chk("jp_flush_sel", int'(bus.addrSel), 1); chk("jp_flush_bub", int'(bus.bubble), 1);
    chk("jp_flush_if", int'(bus.IF_Write), 0);
    tick();
    neg(); chk("jp_after_bub", int'(bus.bubble), 0); chk("jp_cnt12", int'(bus.StallCount), 12);
    tick();

    // Hold for four cycles in the first branch wait cycle (cnt=1)
    bus.Branch = 1;
    tick(); clear_in(); bus.Hold = 1;
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("hold_pc", int'(bus.PC_Write), 0);
      chk("hold_bub", int'(bus.bubble), 0);
      chk("hold_cnt12", int'(bus.StallCount), 12);
      chk("hold_fsm_cnt", int'(dbg_cnt), 1);
      tick();
    end
    bus.Hold = 0;
    neg(); chk("hold_res_w1", int'(bus.bubble), 1);
    tick(); bus.ALUZero = 1;
    neg(); chk("hold_res_w2", int'(bus.bubble), 1);
    tick(); bus.ALUZero = 0;
    neg(); chk("hold_redir", int'(bus.addrSel), 2);
    tick();

    // Clear during a bubble, then count the rest of the stall
    set_load(9, 0, 9, 0, 0); bus.CntClr = 1;
    neg(); chk("clr_bub", int'(bus.bubble), 1);
    tick(); clear_in();
    neg(); chk("clr_cnt0", int'(bus.StallCount), 0);
    tick();
    neg(); chk("clr_cnt1", int'(bus.StallCount), 1);
    tick();
    neg(); chk("clr_cnt2", int'(bus.StallCount), 2);
    tick();

    // Saturation: 7 load hazards = 21 more bubbles
    for (int i = 0; i < 7; i++) begin
      set_load(4, 0, 4, 0, 0);
      tick(); clear_in();
      tick();
      tick();
    end
    neg(); chk("sat_cnt15", int'(bus.StallCount), MAXC);
    tick();

    // Hold and clear together: cleared, not incremented
    bus.Hold = 1; bus.CntClr = 1;
    tick(); clear_in();
    neg(); chk("holdclr_cnt0", int'(bus.StallCount), 0);
    tick();

    // Reset in the redirect cycle
    bus.Branch = 1;
    tick(); clear_in();
    tick(); bus.ALUZero = 1;
    tick(); bus.ALUZero = 0; rst = 1;
    neg(); chk("rst_tk_sel", int'(bus.addrSel), 0); chk("rst_tk_bub", int'(bus.bubble), 0);
    chk("rst_tk_pc", int'(bus.PC_Write), 1);
    tick(); rst = 0;
    neg(); chk("rst_after_sel", int'(bus.addrSel), 0); chk("rst_after_bub", int'(bus.bubble), 0);
    chk("rst_after_if", int'(bus.IF_Write), 1); chk("rst_after_cnt", int'(bus.StallCount), 0);
    tick();
    tick();

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the directed run is a few hundred cycles long
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule
